// File: rtl/bit_counter_pkg.sv
// Shared definitions for the modulo-N bit counter.
//
// Contents:
//   - step_e        : decoded step direction for one cycle
//   - width_legal   : elaboration-time check of the counter width (2..16)
//   - modulus_legal : elaboration-time check of the modulus (2..2**width)
//   - max_count     : top of the count range, MODULUS-1
package bit_counter_pkg;

  localparam int unsigned MinWidth = 2;
  localparam int unsigned MaxWidth = 16;
  localparam int unsigned MinModulus = 2;

  typedef enum logic [1:0] {
    StepNone = 2'b00,
    StepUp   = 2'b01,
    StepDown = 2'b10
  } step_e;

  function automatic bit width_legal(input int unsigned width);
    return (width >= MinWidth) && (width <= MaxWidth);
  endfunction

  // The width guard keeps the shift in range before the modulus is compared.
  function automatic bit modulus_legal(input int unsigned modulus, input int unsigned width);
    if (!width_legal(width)) begin
      return 1'b0;
    end
    return (modulus >= MinModulus) && (modulus <= (32'd1 << width));
  endfunction

  function automatic int unsigned max_count(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/mod_bit_counter.sv
// Modulo-N bit counter with up/down stepping, synchronous load, wrap or
// saturate at the range ends, and registered boundary status.
//
// Parameters:
//   WIDTH   : counter width in bits (2..16)
//   MODULUS : count range is 0..MODULUS-1 (2..2**WIDTH)
//
// Ports:
//   clk           : rising-edge clock
//   reset         : synchronous, active-high reset
//   ClearCounter  : force Count to 0 (Overflow untouched)
//   LoadCounter   : load LoadValue, clamped to MODULUS-1
//   LoadValue     : value for LoadCounter
//   IncCounter    : step up by one
//   DecCounter    : step down by one (both or neither step = hold)
//   Saturate      : 0 = wrap at range ends, 1 = hold at range ends
//   ClearOverflow : clear the sticky Overflow flag (a same-cycle set wins)
//   Count         : current count, registered
//   Terminal      : high while Count == MODULUS-1
//   Wrapped       : one-cycle registered pulse on a wrap/saturate event
//   Overflow      : sticky flag, set on boundary events and clamped loads
module mod_bit_counter
  import bit_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ClearCounter,
  input  logic             LoadCounter,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             IncCounter,
  input  logic             DecCounter,
  input  logic             Saturate,
  input  logic             ClearOverflow,
  output logic [WIDTH-1:0] Count,
  output logic             Terminal,
  output logic             Wrapped,
  output logic             Overflow
);

  // Parameter legality, rejected at elaboration.
  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("mod_bit_counter: WIDTH must be in 2..16");
  end
  if (!modulus_legal(MODULUS, WIDTH)) begin : g_bad_modulus
    $error("mod_bit_counter: MODULUS must be in 2..2**WIDTH");
  end

  // Boundary arithmetic is done one bit wider so MODULUS == 2**WIDTH still
  // fits and the load compare cannot alias.
  localparam int unsigned MaxCount = max_count(MODULUS);
  localparam logic [WIDTH:0] MaxCountExt = (WIDTH + 1)'(MaxCount);
  localparam logic [WIDTH:0] ModulusExt = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] OneExt = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MaxCountVal = WIDTH'(MaxCount);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             overflow_q, overflow_d;

  step_e            step;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   count_inc;
  logic [WIDTH:0]   count_dec;
  logic [WIDTH:0]   load_ext;
  logic             at_max;
  logic             at_zero;
  logic             overflow_set;

  assign count_ext = {1'b0, count_q};
  assign count_inc = count_ext + OneExt;
  assign count_dec = count_ext - OneExt;
  assign load_ext  = {1'b0, LoadValue};
  assign at_max    = (count_ext == MaxCountExt);
  assign at_zero   = (count_q == '0);

  // Inc XOR Dec selects a direction; both or neither means hold.
  always_comb begin
    step = StepNone;
    if (IncCounter && !DecCounter) begin
      step = StepUp;
    end else if (DecCounter && !IncCounter) begin
      step = StepDown;
    end
  end

  always_comb begin
    count_d      = count_q;
    wrapped_d    = 1'b0;
    overflow_set = 1'b0;

    if (ClearCounter) begin
      count_d = '0;
    end else if (LoadCounter) begin
      if (load_ext >= ModulusExt) begin
        // Out-of-range load clamps to the top of the range; no wrap pulse.
        count_d      = MaxCountVal;
        overflow_set = 1'b1;
      end else begin
        count_d = LoadValue;
      end
    end else begin
      unique case (step)
        StepUp: begin
          if (at_max) begin
            count_d      = Saturate ? count_q : '0;
            wrapped_d    = 1'b1;
            overflow_set = 1'b1;
          end else begin
            count_d = count_inc[WIDTH-1:0];
          end
        end
        StepDown: begin
          if (at_zero) begin
            count_d      = Saturate ? count_q : MaxCountVal;
            wrapped_d    = 1'b1;
            overflow_set = 1'b1;
          end else begin
            count_d = count_dec[WIDTH-1:0];
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end

    // A set in the same cycle beats ClearOverflow.
    overflow_d = overflow_set | (overflow_q & ~ClearOverflow);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      overflow_q <= overflow_d;
    end
  end

  assign Count    = count_q;
  assign Terminal = (count_q == MaxCountVal);
  assign Wrapped  = wrapped_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_mod_bit_counter.sv
module tb_mod_bit_counter;

  localparam int unsigned W = 4;
  localparam int unsigned M = 10;

  logic         clk;
  logic         reset;
  logic         clear_counter;
  logic         load_counter;
  logic [W-1:0] load_value;
  logic         inc_counter;
  logic         dec_counter;
  logic         saturate;
  logic         clear_overflow;
  logic [W-1:0] count;
  logic         terminal;
  logic         wrapped;
  logic         overflow;

  mod_bit_counter #(
    .WIDTH  (W),
    .MODULUS(M)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ClearCounter (clear_counter),
    .LoadCounter  (load_counter),
    .LoadValue    (load_value),
    .IncCounter   (inc_counter),
    .DecCounter   (dec_counter),
    .Saturate     (saturate),
    .ClearOverflow(clear_overflow),
    .Count        (count),
    .Terminal     (terminal),
    .Wrapped      (wrapped),
    .Overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    bit       rst;
    bit       clr;
    bit       ld;
    bit [3:0] ldv;
    bit       inc;
    bit       dec;
    bit       sat;
    bit       clro;
    bit [3:0] exp_cnt;
    bit       exp_term;
    bit       exp_wrap;
    bit       exp_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests;
  int   n_failed;

  function automatic vec_t mk(input string name, input bit rst, input bit clr, input bit ld,
                              input bit [3:0] ldv, input bit inc, input bit dec, input bit sat,
                              input bit clro, input bit [3:0] ec, input bit et, input bit ew,
                              input bit eo);
    vec_t v;
    v.name = name; v.rst = rst; v.clr = clr; v.ld = ld; v.ldv = ldv;
    v.inc = inc; v.dec = dec; v.sat = sat; v.clro = clro;
    v.exp_cnt = ec; v.exp_term = et; v.exp_wrap = ew; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then score the DUT
  // output just after the sampling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset          = v.rst;
    clear_counter  = v.clr;
    load_counter   = v.ld;
    load_value     = v.ldv;
    inc_counter    = v.inc;
    dec_counter    = v.dec;
    saturate       = v.sat;
    clear_overflow = v.clro;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({v.name, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".count"}, int'(count), int'(e.exp_cnt));
      check({e.name, ".terminal"}, int'(terminal), int'(e.exp_term));
      check({e.name, ".wrapped"}, int'(wrapped), int'(e.exp_wrap));
      check({e.name, ".overflow"}, int'(overflow), int'(e.exp_ovf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests  = 0;
    n_failed = 0;
    reset = 1'b1; clear_counter = 1'b0; load_counter = 1'b0; load_value = '0;
    inc_counter = 1'b0; dec_counter = 1'b0; saturate = 1'b0; clear_overflow = 1'b0;

    //                    name         rst clr ld ldv inc dec sat clro cnt term wrap ovf
    vecs.push_back(mk("reset",         1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      vecs.push_back(mk($sformatf("inc_wrap%0d", i), 0, 0, 0, 0, 1, 0, 0, 0,
                        4'(i), (i == 9), 0, 0));
    end
    vecs.push_back(mk("inc_wrap10",    0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(mk("inc_wrap11",    0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 1));
    vecs.push_back(mk("inc_wrap12",    0, 0, 0, 0,  1, 0, 0, 0,  2, 0, 0, 1));
    vecs.push_back(mk("clro",          0, 0, 0, 0,  0, 0, 0, 1,  2, 0, 0, 0));
    for (int i = 1; i <= 12; i++) begin
      vecs.push_back(mk($sformatf("inc_sat%0d", i), 0, 0, 0, 0, 1, 0, 1, 0,
                        (i >= 7) ? 4'd9 : 4'(2 + i), (i >= 7), (i >= 8), (i >= 8)));
    end
    vecs.push_back(mk("inc_and_dec",   0, 0, 0, 0,  1, 1, 0, 0,  9, 1, 0, 1));
    vecs.push_back(mk("clr_at_max",    0, 1, 0, 0,  1, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk("clro2",         0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk("dec_wrap",      0, 0, 0, 0,  0, 1, 0, 0,  9, 1, 1, 1));
    vecs.push_back(mk("clr",           0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk("clro3",         0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk("dec_sat",       0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 1, 1));
    vecs.push_back(mk("clro_vs_set",   0, 0, 0, 0,  0, 1, 1, 1,  0, 0, 1, 1));
    vecs.push_back(mk("clro4",         0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk("load5_inc",     0, 0, 1, 5,  1, 0, 0, 0,  5, 0, 0, 0));
    vecs.push_back(mk("load12_inc",    0, 0, 1, 12, 1, 0, 0, 0,  9, 1, 0, 1));
    vecs.push_back(mk("clro5",         0, 0, 0, 0,  0, 0, 0, 1,  9, 1, 0, 0));
    vecs.push_back(mk("load9",         0, 0, 1, 9,  0, 0, 0, 0,  9, 1, 0, 0));
    vecs.push_back(mk("load10",        0, 0, 1, 10, 0, 0, 0, 0,  9, 1, 0, 1));
    vecs.push_back(mk("clro6",         0, 0, 0, 0,  0, 0, 0, 1,  9, 1, 0, 0));
    vecs.push_back(mk("load15",        0, 0, 1, 15, 0, 0, 0, 0,  9, 1, 0, 1));
    vecs.push_back(mk("clro7",         0, 0, 0, 0,  0, 0, 0, 1,  9, 1, 0, 0));
    vecs.push_back(mk("clr_inc_noovf", 0, 1, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk("load7",         0, 0, 1, 7,  0, 0, 0, 0,  7, 0, 0, 0));
    vecs.push_back(mk("dec_mid",       0, 0, 0, 0,  0, 1, 0, 0,  6, 0, 0, 0));
    vecs.push_back(mk("load7b",        0, 0, 1, 7,  0, 0, 0, 0,  7, 0, 0, 0));
    vecs.push_back(mk("reset_at7",     1, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
    end

    // Reset on the cycle after a wrap cancels Wrapped and the sticky flag.
    apply(mk("hs_load9",   0, 0, 1, 9, 0, 0, 0, 0,  9, 1, 0, 0));
    apply(mk("hs_wrap",    0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1));
    apply(mk("hs_reset",   1, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    // Back-to-back saturating down steps keep Wrapped continuously high.
    for (int i = 0; i < 3; i++) begin
      apply(mk($sformatf("hs_dec_sat%0d", i), 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
    end
    apply(mk("hs_idle",    0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1));

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
